// File: rtl/add_sub_pkg.sv
// add_sub_pkg
// Shared definitions for the digit-serial adder/subtractor:
//   - state_e / ST_* : FSM state encoding (IDLE, BUSY, DONE)
//   - clog2          : counter width helper (never returns less than 1)
//   - sat_max/sat_min: signed saturation constants for a given width
// Optional feature macro used by the top: ADDSUB_SAT_EN.
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Plain constants used for the state register itself.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Widest datapath the saturation helpers can describe.
    localparam int MAX_WIDTH = 256;

    // Bits needed to count 0..v-1; clamped to 1 so a single-digit
    // configuration still gets a legal (unused) counter bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Largest positive two's-complement value of the given width.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Most negative two's-complement value of the given width.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i == width - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/digit_serial_add_sub_if.sv
// digit_serial_add_sub_if
// Operand and result channels of the digit-serial adder/subtractor.
//   in_valid/in_ready, a, b, s          : operand channel (master -> slave)
//   out_valid/out_ready, sum, cout, ovf,
//   zero, neg                           : result channel (slave -> master)
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and its payload until that edge;
// ready may be deasserted indefinitely; the payload is only meaningful
// while valid is 1.
interface digit_serial_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, s, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, s, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/digit_adder.sv
// digit_adder
// Combinational DIGIT-bit ripple adder built from full_adder cells.
//   a, b  : DIGIT-bit addends
//   cin   : carry into bit 0
//   sum   : DIGIT-bit sum
//   cout  : carry out of bit DIGIT-1
//   c_msb : carry into bit DIGIT-1 (signed overflow needs it on the top digit)
module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    assign cout  = carry[DIGIT];
    assign c_msb = carry[DIGIT-1];
endmodule

// File: rtl/full_adder.sv
// full_adder
// One-bit full adder.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/digit_serial_add_sub.sv
// digit_serial_add_sub
// Multi-cycle two's-complement adder/subtractor. Operands are accepted on the
// operand channel, processed DIGIT bits per cycle (LSB digit first) through a
// single shared digit_adder, and the result plus flags are offered on the
// result channel until consumed.
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   bus       : digit_serial_add_sub_if slave (operands in, result/flags out)
//   dbg_state : current FSM state (ST_IDLE/ST_BUSY/ST_DONE)
// Optional feature macro: ADDSUB_SAT_EN -- clamp sum to signed saturation on
// overflow. Without it the wrapped result is produced and no clamp exists.
// WIDTH must be a multiple of DIGIT and no wider than MAX_WIDTH.
module digit_serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_add_sub_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX_W = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN_W = WIDTH'(sat_min(WIDTH));
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;      // b already conditionally inverted
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;  // partial sum, filled from the top down
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] acc_next;
    logic             ovf_next;
    logic [WIDTH-1:0] res_sum;

    // Operands shift right each BUSY cycle, so the active digit is always
    // the low DIGIT bits and no per-digit mux is needed.
    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout),
        .c_msb(dig_cmsb)
    );

    always_comb begin
        // New digit enters at the top; after NUM_DIGITS shifts the LSB digit
        // has reached bit 0 and acc holds the full result.
        acc_next = acc_q >> DIGIT;
        acc_next[WIDTH-1 -: DIGIT] = dig_sum;
        // On the last digit, dig_cmsb/dig_cout are the carries into/out of
        // bit WIDTH-1.
        ovf_next = dig_cmsb ^ dig_cout;
`ifdef ADDSUB_SAT_EN
        // On overflow the wrapped sign is opposite to the true sign, so a
        // negative wrapped result means a positive overflow.
        if (ovf_next) begin
            res_sum = acc_next[WIDTH-1] ? SAT_MAX_W : SAT_MIN_W;
        end else begin
            res_sum = acc_next;
        end
`else
        res_sum = acc_next;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    // Subtract as a + ~b + 1: the +1 comes in as carry.
                    b_d     = bus.b ^ {WIDTH{bus.s}};
                    carry_d = bus.s;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                acc_d   = acc_next;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_sum;
                    cout_d  = dig_cout;
                    ovf_d   = ovf_next;
                    zero_d  = (res_sum == '0);
                    neg_d   = res_sum[WIDTH-1];
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign dbg_state     = state_q;

endmodule
